// File: rtl/tile_move_renderer_if.sv
// Move handshake, wall-map query, tile-ROM and pixel-plot signals of tile_move_renderer.
// master = game/controller side, slave = the renderer.
interface tile_move_renderer_if #(
  parameter int TILE_BITS   = 3,
  parameter int COLOUR_BITS = 24
);
  logic                   move_valid;
  logic [2:0]             move;
  logic                   move_ready;
  logic                   move_done;
  logic [4:0]             wall_x;
  logic [4:0]             wall_y;
  logic                   wall_hit;
  logic [4:0]             player_x;
  logic [4:0]             player_y;
  logic [2*TILE_BITS:0]   rom_address;
  logic [COLOUR_BITS-1:0] rom_data;
  logic [7:0]             vga_x;
  logic [6:0]             vga_y;
  logic [COLOUR_BITS-1:0] vga_colour;
  logic                   vga_plot;

  modport master (
    output move_valid, move, wall_hit, rom_data,
    input  move_ready, move_done, wall_x, wall_y, player_x, player_y,
           rom_address, vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    input  move_valid, move, wall_hit, rom_data,
    output move_ready, move_done, wall_x, wall_y, player_x, player_y,
           rom_address, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/tile_move_renderer.sv
// Player-tile movement and redraw engine: validates moves against grid bounds and a wall map,
// then erases the old cell and draws the new one by streaming tile-ROM pixels to the plotter.
module tile_move_renderer #(
  parameter int TILE_BITS   = 3,
  parameter int GRID_W      = 20,
  parameter int GRID_H      = 15,
  parameter int COLOUR_BITS = 24,
  parameter int START_X     = 0,
  parameter int START_Y     = 0
) (
  input logic                 CLOCK_50,
  input logic                 resetn,
  tile_move_renderer_if.slave bus
);

  localparam int PW = 2 * TILE_BITS;
  localparam logic [PW-1:0] PIX_ONE = {{(PW-1){1'b0}}, 1'b1};

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_ERASE = 3'd3;
  localparam logic [2:0] S_DRAW  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam logic [2:0] M_UP    = 3'd1;
  localparam logic [2:0] M_DOWN  = 3'd2;
  localparam logic [2:0] M_LEFT  = 3'd3;
  localparam logic [2:0] M_RIGHT = 3'd4;

  logic [2:0]           state;
  logic [2:0]           mv;
  logic [PW-1:0]        pix;
  logic [4:0]           player_x, player_y;
  logic                 armed;      // low only in the first cycle after reset release
  logic                 init_pass;  // DRAIN returns to IDLE (power-up tile) rather than DONE
  logic [7:0]           vga_x;
  logic [6:0]           vga_y;
  logic                 vga_plot;

  logic [TILE_BITS-1:0] row, col;
  logic [4:0]           tgt_x, tgt_y;
  logic                 at_edge, no_move, blocked, issuing, tile_sel, pix_last;
  logic [7:0]           plot_x;
  logic [6:0]           plot_y;

  assign {row, col} = pix;

  // Target cell; edge tests happen before the +/-1 so a 5-bit coordinate never wraps.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves one unassigned and no latch is inferred.
    tgt_x   = player_x;
    tgt_y   = player_y;
    at_edge = 1'b0;
    no_move = 1'b0;
    case (mv)
      M_UP:    if (player_y == 5'd0)              at_edge = 1'b1; else tgt_y = player_y - 5'd1;
      M_DOWN:  if (player_y == 5'(GRID_H - 1))    at_edge = 1'b1; else tgt_y = player_y + 5'd1;
      M_LEFT:  if (player_x == 5'd0)              at_edge = 1'b1; else tgt_x = player_x - 5'd1;
      M_RIGHT: if (player_x == 5'(GRID_W - 1))    at_edge = 1'b1; else tgt_x = player_x + 5'd1;
      default: no_move = 1'b1;
    endcase
  end

  assign blocked  = no_move | at_edge | bus.wall_hit;
  assign issuing  = (state == S_INIT && armed) || state == S_ERASE || state == S_DRAW;
  assign tile_sel = (state != S_ERASE);
  assign pix_last = &pix;

  // INIT and ERASE use the current cell; by DRAW the position already holds the target.
  assign plot_x = 8'((int'(player_x) << TILE_BITS) + int'(col));
  assign plot_y = 7'((int'(player_y) << TILE_BITS) + int'(row));

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state     <= S_INIT;
      mv        <= 3'd0;
      pix       <= '0;
      player_x  <= 5'(START_X);
      player_y  <= 5'(START_Y);
      armed     <= 1'b0;
      init_pass <= 1'b1;
      vga_x     <= 8'd0;
      vga_y     <= 7'd0;
      vga_plot  <= 1'b0;
    end else begin
      armed    <= 1'b1;
      // Plot attributes are the address-cycle values delayed one cycle to meet the ROM data.
      vga_plot <= issuing;
      if (issuing) begin
        vga_x <= plot_x;
        vga_y <= plot_y;
        pix   <= pix + PIX_ONE;
      end
      case (state)
        S_INIT:  if (armed && pix_last) state <= S_DRAIN;
        S_IDLE:  if (bus.move_valid) begin
                   mv    <= bus.move;
                   state <= S_CHECK;
                 end
        S_CHECK: state <= blocked ? S_DONE : S_ERASE;
        S_ERASE: if (pix_last) begin
                   player_x <= tgt_x;
                   player_y <= tgt_y;
                   state    <= S_DRAW;
                 end
        S_DRAW:  if (pix_last) state <= S_DRAIN;
        S_DRAIN: begin
                   init_pass <= 1'b0;
                   state     <= init_pass ? S_IDLE : S_DONE;
                 end
        S_DONE:  state <= S_IDLE;
        default: state <= S_INIT;
      endcase
    end
  end

  assign bus.move_ready  = (state == S_IDLE);
  assign bus.move_done   = (state == S_DONE);
  assign bus.wall_x      = tgt_x;
  assign bus.wall_y      = tgt_y;
  assign bus.player_x    = player_x;
  assign bus.player_y    = player_y;
  assign bus.rom_address = issuing ? {tile_sel, pix} : '0;
  assign bus.vga_x       = vga_x;
  assign bus.vga_y       = vga_y;
  assign bus.vga_plot    = vga_plot;
  assign bus.vga_colour  = vga_plot ? bus.rom_data : {COLOUR_BITS{1'b0}};

endmodule

// File: tb/tb_tile_move_renderer.sv
// Scoreboard bench for tile_move_renderer: a cell-level game model predicts every plotted pixel,
// handshake timing and final position for directed and random moves, including a mid-draw reset.
module tb_tile_move_renderer;

  localparam int T    = 8;
  localparam int NPIX = T * T;
  localparam int GW   = 20;
  localparam int GH   = 15;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  tile_move_renderer_if #(.TILE_BITS(3), .COLOUR_BITS(24)) bus ();

  tile_move_renderer #(
    .TILE_BITS(3), .GRID_W(GW), .GRID_H(GH), .COLOUR_BITS(24), .START_X(0), .START_Y(0)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .resetn  (resetn),
    .bus     (bus)
  );

  typedef struct packed {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [23:0] c;
  } plot_t;

  plot_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  int    done_cnt = 0;
  int    px = 0, py = 0;
  logic  wall [0:31][0:31];

  // Combinational wall map and a 1-cycle address-coded tile ROM.
  assign bus.wall_hit = wall[bus.wall_x][bus.wall_y];
  always @(posedge CLOCK_50)
    bus.rom_data <= {8'hC3, 1'b0, bus.rom_address, ~{1'b0, bus.rom_address}};

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic plot_t exp_plot(int cx, int cy, int tile, int r, int c);
    plot_t p;
    int    a;
    a   = tile * NPIX + r * T + c;
    p.x = 8'(cx * T + c);
    p.y = 7'(cy * T + r);
    p.c = {8'hC3, 8'(a), ~8'(a)};
    return p;
  endfunction

  task automatic push_tile(int cx, int cy, int tile);
    for (int r = 0; r < T; r++)
      for (int c = 0; c < T; c++)
        exp_q.push_back(exp_plot(cx, cy, tile, r, c));
  endtask

  // Monitor: every plot must match the head of the expected queue.
  always @(negedge CLOCK_50) begin
    plot_t e;
    if (resetn) begin
      if (bus.move_done) done_cnt++;
      if (bus.vga_plot) begin
        if (exp_q.size() == 0) begin
          check("unexpected_plot", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("plot_x", bus.vga_x, e.x);
          check("plot_y", bus.vga_y, e.y);
          check("plot_colour", bus.vga_colour, e.c);
        end
      end
    end
  end

  task automatic reset_and_init();
    int n, d0;
    resetn = 1'b0;
    bus.move_valid = 1'b0;
    bus.move = 3'd0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_vga_plot", bus.vga_plot, 0);
    check("rst_vga_x", bus.vga_x, 0);
    check("rst_vga_y", bus.vga_y, 0);
    check("rst_vga_colour", bus.vga_colour, 0);
    check("rst_rom_address", bus.rom_address, 0);
    check("rst_move_ready", bus.move_ready, 0);
    check("rst_move_done", bus.move_done, 0);
    check("rst_player_x", bus.player_x, 0);
    check("rst_player_y", bus.player_y, 0);
    exp_q.delete();
    px = 0;
    py = 0;
    push_tile(0, 0, 1);
    d0 = done_cnt;
    resetn = 1'b1;
    n = 0;
    while (n < 200) begin
      @(negedge CLOCK_50);
      n++;
      if (bus.move_ready) break;
    end
    check("init_ready_cycle", n, 66);
    check("init_plots_left", exp_q.size(), 0);
    check("init_no_done", done_cnt - d0, 0);
  endtask

  // Predicts the move at cell level, pushes expected plots, then times the handshake.
  task automatic run_move(input logic [2:0] m, input int pulse_at, input int reset_at);
    int   dx, dy, nx, ny, n, first_plot, done_at, d0;
    logic in_range, legal;
    dx = 0;
    dy = 0;
    case (m)
      3'd1: dy = -1;
      3'd2: dy = 1;
      3'd3: dx = -1;
      3'd4: dx = 1;
      default: ;
    endcase
    nx = px + dx;
    ny = py + dy;
    in_range = (nx >= 0 && nx < GW && ny >= 0 && ny < GH);
    legal = 1'b0;
    if (in_range && (dx != 0 || dy != 0)) legal = !wall[nx][ny];
    if (legal) begin
      push_tile(px, py, 0);
      push_tile(nx, ny, 1);
    end
    n = 0;
    while (!bus.move_ready && n < 300) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("ready_before_move", bus.move_ready, 1);
    d0 = done_cnt;
    bus.move_valid = 1'b1;
    bus.move = m;
    @(posedge CLOCK_50);
    #1;
    bus.move_valid = 1'b0;
    bus.move = 3'd0;
    n = 0;
    first_plot = -1;
    done_at = -1;
    while (n < 400) begin
      @(negedge CLOCK_50);
      if (n == 0 && in_range) begin
        check("wall_x", bus.wall_x, nx);
        check("wall_y", bus.wall_y, ny);
      end
      if (n == reset_at) begin
        resetn = 1'b0;
        #1;
        check("midreset_vga_plot", bus.vga_plot, 0);
        check("midreset_player_x", bus.player_x, 0);
        check("midreset_player_y", bus.player_y, 0);
        exp_q.delete();
        px = 0;
        py = 0;
        return;
      end
      if (bus.move_ready) break;
      if (bus.vga_plot && first_plot < 0) first_plot = n;
      if (bus.move_done) done_at = n;
      if (n == pulse_at) begin
        bus.move_valid = 1'b1;
        bus.move = 3'd3;
      end else if (n == pulse_at + 1) begin
        bus.move_valid = 1'b0;
        bus.move = 3'd0;
      end
      n++;
    end
    check("ready_low_cycles", n, legal ? 131 : 2);
    check("first_plot_cycle", first_plot, legal ? 2 : -1);
    check("done_cycle", done_at, legal ? 130 : 1);
    check("done_count", done_cnt - d0, 1);
    if (legal) begin
      px = nx;
      py = ny;
    end
    check("player_x", bus.player_x, px);
    check("player_y", bus.player_y, py);
    check("plots_left", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++)
        wall[i][j] = 1'b0;
    bus.move_valid = 1'b0;
    bus.move = 3'd0;

    reset_and_init();

    // Blocked at the origin: edges and non-moves.
    run_move(3'd1, -1, -1);
    run_move(3'd3, -1, -1);
    run_move(3'd0, -1, -1);
    run_move(3'd6, -1, -1);

    // Legal move right with a stray request in the middle of the redraw.
    run_move(3'd4, 70, -1);

    // Wall directly to the right.
    wall[2][0] = 1'b1;
    run_move(3'd4, -1, -1);
    wall[2][0] = 1'b0;

    // Walk to the far corner, then push against both far edges.
    for (int i = 0; i < GW - 2; i++) run_move(3'd4, -1, -1);
    for (int i = 0; i < GH - 1; i++) run_move(3'd2, -1, -1);
    check("corner_x", px, 19);
    check("corner_y", py, 14);
    run_move(3'd4, -1, -1);
    run_move(3'd2, -1, -1);

    // Random walls and random moves.
    for (int i = 0; i < GW; i++)
      for (int j = 0; j < GH; j++)
        wall[i][j] = ($urandom_range(0, 4) == 0);
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 9) < 8) run_move(3'(1 + $urandom_range(0, 3)), -1, -1);
      else run_move(3'($urandom_range(0, 7)), -1, -1);
    end

    // Reset during DRAW pixel 30, then the power-up tile again.
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++)
        wall[i][j] = 1'b0;
    run_move((px > 0) ? 3'd3 : 3'd4, -1, 65 + 30);
    reset_and_init();
    run_move(3'd2, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tile_move_renderer.md
# tile_move_renderer

Player-tile movement and redraw engine for the tile-grid game. It accepts discrete move commands and checks grid bounds and an external wall map. For each legal move it erases the player tile at the old cell with the background tile and draws the player tile at the new cell. The tile bitmaps are streamed from a synchronous tile ROM into the vga_adapter pixel-plot port. It generalises the fixed 8-pixel, 20x15 player-position logic of the top level into a parametrised block with its own redraw FSM and move handshake.

## Interface

- TILE_BITS, 3: log2 of tile edge; T = 2^TILE_BITS pixels
- GRID_W, 20: grid width in tiles; GRID_W*T ≤ 160
- GRID_H, 15: grid height in tiles; GRID_H*T ≤ 120
- COLOUR_BITS, 24: pixel colour width
- START_X, 0 / START_Y, 0: player cell after reset

- CLOCK_50  in  1  system clock, all logic on rising edge
- resetn  in  1  reset, asynchronous, active-low
- move_valid  in  1  move request strobe, sampled only while move_ready=1
- move  in  3  0 none, 1 up (y-1), 2 down (y+1), 3 left (x-1), 4 right (x+1), 5-7 treated as none
- move_ready  out  1  high in IDLE only
- move_done  out  1  one-cycle pulse at end of every accepted move, including blocked moves
- wall_x  out  5  target cell x, valid in CHECK
- wall_y  out  5  target cell y, valid in CHECK
- wall_hit  in  1  combinational map answer for (wall_x, wall_y), sampled at end of CHECK
- player_x  out  5  current cell x
- player_y  out  5  current cell y
- rom_address  out  1+2*TILE_BITS  {tile_sel, row, col}; tile_sel 0 = background, 1 = player
- rom_data  in  COLOUR_BITS  ROM output, valid one cycle after address
- vga_x  out  8  plot pixel x
- vga_y  out  7  plot pixel y
- vga_colour  out  COLOUR_BITS  plot colour (= rom_data)
- vga_plot  out  1  pixel write enable

## Operation

- States: INIT, IDLE, CHECK, ERASE, DRAW, DRAIN, DONE.
- INIT (entered on reset):
  - Issues T² addresses with tile_sel=1 at cell (START_X, START_Y).
  - Then goes to DRAIN, then to IDLE. No move_done pulse.
- IDLE:
  - move_ready=1.
  - move_valid=1 latches move, then goes to CHECK.
  - move_valid outside IDLE is ignored (dropped, not queued).
- CHECK (1 cycle):
  - Computes target cell from the latched move.
  - The move is blocked if any of these hold: move is none/5-7; the target is outside 0..GRID_W-1 or 0..GRID_H-1 (no wrap, no 5-bit underflow); wall_hit=1.
  - Blocked: go to DONE, no plot, position unchanged.
  - Legal: go to ERASE.
- ERASE:
  - T² address cycles with tile_sel=0 at the old cell.
  - On exit, player_x/player_y load the target, then go to DRAW.
- DRAW: T² address cycles with tile_sel=1 at the new cell, then DRAIN.
- DRAIN: 1 cycle, emits the last pipelined plot.
- DONE: 1 cycle, move_done=1, then IDLE.
- Pixel order is row-major, col fastest; the (row, col) counter wraps to 0 between passes.
- Pixel coordinates: vga_x = cell_x*T + col, vga_y = cell_y*T + row, truncated to 8/7 bits. Parameter limits guarantee no overflow.

## Timing

- ROM latency is 1 cycle. vga_x, vga_y and vga_plot are the address-cycle values registered once, so they align with rom_data.
- ERASE→DRAW is seamless: plots are continuous for 2T² cycles with no gap.
- Legal move: move_ready low for 2T²+3 cycles (131 at T=8). First vga_plot comes 2 cycles after the accept edge.
- Blocked move: move_ready low for 2 cycles. move_done is on the second cycle.
- Reset (async, any state):
  - Values: state=INIT, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, rom_address=0, move_ready=0, move_done=0, player_x=START_X, player_y=START_Y.
  - After release: T² INIT issue cycles, then DRAIN, then move_ready=1 in cycle T²+2.
- Reset mid-ERASE/DRAW aborts the redraw; the partially drawn screen is not repaired except by the INIT tile.

## Test plan

- Reset release, T=8, start (0,0), ROM = address-coded data:
  - 64 plots, x 0-7, y 0-7, row-major, rom_address 64..127.
  - move_ready rises at cycle 66.
  - No move_done.
- From (0,0), move=4, wall_hit=0:
  - 64 plots at x 0-7 with tile 0 data, then 64 plots at x 8-15 with tile 1 data.
  - player_x=1, one move_done, ready low 131 cycles.
  - A move_valid pulsed mid-draw is ignored.
- From (0,0), move=1 and move=3: no plot, move_done after 2 cycles, position stays (0,0).
- From (1,0), move=4 with wall_hit=1 while wall_x=2, wall_y=0: blocked, no plot, player_x stays 1.
- Walk to (19,14):
  - The last draw covers x 152-159, y 112-119.
  - Then move=4 and move=2 are blocked; x does not wrap to 0.
- resetn low during DRAW pixel 30:
  - vga_plot=0 immediately, position returns to (0,0).
  - After release, INIT redraws at (0,0).
